// File: rtl/fwd_scoreboard.sv
// EXE bypass-source select plus per-GPR long-latency scoreboard driving the ID stall.
// Select and stall are zero-latency combinational; scoreboard state updates one edge later; no backpressure beyond id_stall_o.
module fwd_scoreboard #(
    parameter int NUM_RD  = 2,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 3,
    parameter int SEL_W   = $clog2(NUM_FWD + 1),
    parameter int PERF_W  = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_RD-1:0]         ex_rd_en_i,
    input  logic [NUM_RD*5-1:0]       ex_rd_addr_i,
    input  logic [NUM_FWD-1:0]        fwd_wr_i,
    input  logic [NUM_FWD*5-1:0]      fwd_dst_i,
    output logic [NUM_RD*SEL_W-1:0]   ex_fwd_sel_o,
    input  logic [NUM_RD-1:0]         id_rd_en_i,
    input  logic [NUM_RD*5-1:0]       id_rd_addr_i,
    input  logic                      iss_valid_i,
    input  logic [4:0]                iss_dst_i,
    input  logic [CNT_W-1:0]          iss_lat_i,
    input  logic                      done_valid_i,
    input  logic [4:0]                done_dst_i,
    input  logic                      hold_i,
    input  logic                      flush_i,
    output logic                      id_stall_o,
    output logic [PERF_W-1:0]         stall_cycles_o
);

    logic [CNT_W-1:0]  cnt_q [32];
    logic [CNT_W-1:0]  cnt_d [32];
    logic [31:0]       unk_q, unk_d;
    logic [31:0]       busy;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

    // Scanning oldest to youngest lets the youngest matching source overwrite.
    always_comb begin
        ex_fwd_sel_o = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (ex_rd_en_i[i] && (ex_rd_addr_i[5*i +: 5] != 5'd0) && fwd_wr_i[k] &&
                    (fwd_dst_i[5*k +: 5] == ex_rd_addr_i[5*i +: 5])) begin
                    ex_fwd_sel_o[SEL_W*i +: SEL_W] = SEL_W'(k + 1);
                end
            end
        end
    end

    // Entry 0 is held at zero state, so r0 can never appear busy.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            busy[r] = (cnt_q[r] != '0) | unk_q[r];
        end
    end

    always_comb begin
        id_stall_o = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (id_rd_en_i[i] && (id_rd_addr_i[5*i +: 5] != 5'd0) &&
                (busy[id_rd_addr_i[5*i +: 5]] ||
                 (iss_valid_i && !flush_i && (iss_dst_i == id_rd_addr_i[5*i +: 5])))) begin
                id_stall_o = 1'b1;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            unk_d[r] = unk_q[r];
        end
        for (int r = 1; r < 32; r++) begin
            if (flush_i) begin
                cnt_d[r] = '0;
                unk_d[r] = 1'b0;
            end else if (iss_valid_i && (iss_dst_i == 5'(r))) begin
                if (iss_lat_i != '0) begin
                    cnt_d[r] = iss_lat_i - CNT_W'(1);
                    unk_d[r] = 1'b0;
                end else begin
                    cnt_d[r] = '0;
                    unk_d[r] = 1'b1;
                end
            end else if (done_valid_i && (done_dst_i == 5'(r))) begin
                cnt_d[r] = '0;
                unk_d[r] = 1'b0;
            end else if (!hold_i && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
        cnt_d[0] = '0;
        unk_d[0] = 1'b0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (id_stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
            unk_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            unk_q       <= unk_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: forward-select vector table plus stall scoreboard sequences.
module tb_fwd_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ex_rd_en;
    logic [9:0]  ex_rd_addr;
    logic [1:0]  fwd_wr;
    logic [9:0]  fwd_dst;
    logic [3:0]  ex_fwd_sel;
    logic [1:0]  id_rd_en;
    logic [9:0]  id_rd_addr;
    logic        iss_valid;
    logic [4:0]  iss_dst;
    logic [2:0]  iss_lat;
    logic        done_valid;
    logic [4:0]  done_dst;
    logic        hold;
    logic        flush;
    logic        id_stall;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    fwd_scoreboard dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ex_rd_en_i     (ex_rd_en),
        .ex_rd_addr_i   (ex_rd_addr),
        .fwd_wr_i       (fwd_wr),
        .fwd_dst_i      (fwd_dst),
        .ex_fwd_sel_o   (ex_fwd_sel),
        .id_rd_en_i     (id_rd_en),
        .id_rd_addr_i   (id_rd_addr),
        .iss_valid_i    (iss_valid),
        .iss_dst_i      (iss_dst),
        .iss_lat_i      (iss_lat),
        .done_valid_i   (done_valid),
        .done_dst_i     (done_dst),
        .hold_i         (hold),
        .flush_i        (flush),
        .id_stall_o     (id_stall),
        .stall_cycles_o (stall_cycles)
    );

    typedef struct {
        logic [1:0] en;
        logic [9:0] addr;
        logic [1:0] wr;
        logic [9:0] dst;
        logic [3:0] exp_sel;
    } fwd_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock cycle with the inputs already set; pulses are cleared after the edge.
    task automatic cyc(input logic exp_stall, input string name);
        logic e;
        exp_q.push_back(exp_stall);
        @(negedge clk);
        e = exp_q.pop_front();
        chk(name, {31'd0, id_stall}, {31'd0, e});
        @(posedge clk);
        #1;
        rst        = 1'b0;
        iss_valid  = 1'b0;
        done_valid = 1'b0;
        hold       = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic read_id(input logic [4:0] r);
        id_rd_en   = 2'b01;
        id_rd_addr = {5'd0, r};
    endtask

    task automatic issue(input logic [4:0] r, input logic [2:0] lat);
        iss_valid = 1'b1;
        iss_dst   = r;
        iss_lat   = lat;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fwd_vec_t vecs[7];
        vecs[0] = '{2'b01, {5'd0, 5'd5}, 2'b11, {5'd5, 5'd5}, 4'b0001};
        vecs[1] = '{2'b01, {5'd0, 5'd5}, 2'b10, {5'd5, 5'd5}, 4'b0010};
        vecs[2] = '{2'b01, {5'd0, 5'd0}, 2'b11, {5'd0, 5'd0}, 4'b0000};
        vecs[3] = '{2'b11, {5'd6, 5'd5}, 2'b11, {5'd5, 5'd6}, 4'b0110};
        vecs[4] = '{2'b10, {5'd6, 5'd5}, 2'b11, {5'd5, 5'd6}, 4'b0100};
        vecs[5] = '{2'b11, {5'd6, 5'd5}, 2'b00, {5'd5, 5'd6}, 4'b0000};
        vecs[6] = '{2'b11, {5'd7, 5'd7}, 2'b11, {5'd7, 5'd3}, 4'b1010};

        rst = 1'b1; ex_rd_en = '0; ex_rd_addr = '0; fwd_wr = '0; fwd_dst = '0;
        id_rd_en = '0; id_rd_addr = '0; iss_valid = 1'b0; iss_dst = '0; iss_lat = '0;
        done_valid = 1'b0; done_dst = '0; hold = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b0, "reset_stall");
        chk("reset_perf", stall_cycles, 32'd0);
        chk("reset_sel", {28'd0, ex_fwd_sel}, 32'd0);

        for (int v = 0; v < 7; v++) begin
            ex_rd_en   = vecs[v].en;
            ex_rd_addr = vecs[v].addr;
            fwd_wr     = vecs[v].wr;
            fwd_dst    = vecs[v].dst;
            @(negedge clk);
            chk($sformatf("fwd_sel_vec%0d", v), {28'd0, ex_fwd_sel}, {28'd0, vecs[v].exp_sel});
        end
        ex_rd_en = '0; fwd_wr = '0;

        // Known latency 2: two stall cycles, then three with one hold cycle.
        read_id(5'd7);
        issue(5'd7, 3'd2); cyc(1'b1, "lat2_c0");
        cyc(1'b1, "lat2_c1");
        cyc(1'b0, "lat2_c2");
        issue(5'd7, 3'd2); cyc(1'b1, "lat2h_c0");
        hold = 1'b1;       cyc(1'b1, "lat2h_c1");
        cyc(1'b1, "lat2h_c2");
        cyc(1'b0, "lat2h_c3");

        // Unknown latency until done.
        read_id(5'd9);
        issue(5'd9, 3'd0); cyc(1'b1, "unk_c0");
        for (int c = 1; c < 10; c++) cyc(1'b1, $sformatf("unk_c%0d", c));
        done_valid = 1'b1; done_dst = 5'd9; cyc(1'b1, "unk_done_cycle");
        cyc(1'b0, "unk_after_done");

        // Issue beats done; flush drops a same-cycle issue.
        read_id(5'd4);
        issue(5'd4, 3'd0); done_valid = 1'b1; done_dst = 5'd4; cyc(1'b1, "iss_done_c0");
        cyc(1'b1, "iss_done_still_busy");
        done_valid = 1'b1; done_dst = 5'd4; cyc(1'b1, "r4_done_cycle");
        cyc(1'b0, "r4_cleared");
        issue(5'd4, 3'd3); flush = 1'b1; cyc(1'b0, "iss_flush_c0");
        cyc(1'b0, "iss_flush_after");
        done_valid = 1'b1; done_dst = 5'd4; cyc(1'b0, "done_idle_ignored");

        // WAW: second issue shortens the wait.
        read_id(5'd3);
        issue(5'd3, 3'd5); cyc(1'b1, "waw_c0");
        issue(5'd3, 3'd1); cyc(1'b1, "waw_c1");
        cyc(1'b0, "waw_c2");

        // Performance counter and reset mid-pending.
        rst = 1'b1; cyc(1'b0, "perf_rst");
        chk("perf_zero", stall_cycles, 32'd0);
        read_id(5'd6);
        issue(5'd6, 3'd4); cyc(1'b1, "perf_c0");
        cyc(1'b1, "perf_c1");
        cyc(1'b1, "perf_c2");
        cyc(1'b1, "perf_c3");
        chk("perf_four", stall_cycles, 32'd4);
        flush = 1'b1; cyc(1'b0, "perf_flush");
        chk("perf_keep_on_flush", stall_cycles, 32'd4);
        issue(5'd6, 3'd0); cyc(1'b1, "r6_pending");
        chk("perf_five", stall_cycles, 32'd5);
        rst = 1'b1; cyc(1'b1, "r6_rst_cycle");
        chk("perf_after_rst", stall_cycles, 32'd0);
        cyc(1'b0, "r6_after_rst");
        chk("perf_stays_zero", stall_cycles, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and hazard unit for the integer pipeline. It combines two jobs. The first is combinational bypass-source selection for NUM_RD EXE read ports across NUM_FWD producer stages. The second is a registered per-register scoreboard that tracks long-latency writers (loads, mul/div, CP0 reads) and raises an ID-stage stall until their results are forwardable. It sits beside the ID/EXE pipeline registers and drives the EXE operand muxes and the ID/IF hold logic.

## Interface
- NUM_RD, 2, number of operand read ports (ID and EXE side).
- NUM_FWD, 2, number of forwarding sources; index 0 is the youngest (MEM), then WB, and so on.
- CNT_W, 3, width of the latency countdown; the maximum known latency is 2^CNT_W-1.
- SEL_W, $clog2(NUM_FWD+1), derived; the width of each select field.
- PERF_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- ex_rd_en  in  NUM_RD  EXE port i actually consumes a GPR.
- ex_rd_addr  in  NUM_RD*5  EXE read address; port i occupies bits [5i+4:5i].
- fwd_wr  in  NUM_FWD  source k will write the GPR file.
- fwd_dst  in  NUM_FWD*5  source k destination; source k occupies bits [5k+4:5k].
- ex_fwd_sel  out  NUM_RD*SEL_W  per-port select: 0 selects the register file, k selects source k-1.
- id_rd_en  in  NUM_RD  ID port i reads a GPR.
- id_rd_addr  in  NUM_RD*5  ID read addresses.
- iss_valid  in  1  a long-latency op leaves ID this cycle.
- iss_dst  in  5  destination of that op.
- iss_lat  in  CNT_W  stall cycles required; 0 means unknown latency.
- done_valid  in  1  an unknown-latency op has completed.
- done_dst  in  5  destination of the completed op.
- hold  in  1  pipeline frozen (e.g. cache miss); countdowns pause.
- flush  in  1  exception/ERET; discard all pending entries.
- id_stall  out  1  ID must hold.
- stall_cycles  out  PERF_W  saturating count of cycles with id_stall=1.

## Operation
State per register r in 1..31:
- cnt[r] (CNT_W bits).
- unk[r] (1 bit).
- busy[r] = (cnt[r]!=0) | unk[r]. Register 0 has no state and is never busy.

Forward select, purely combinational:
- For port i, ex_fwd_sel = the smallest k+1 such that ex_rd_en[i], ex_rd_addr!=0, fwd_wr[k] and fwd_dst[k]==ex_rd_addr.
- If no source matches, ex_fwd_sel = 0.
- The youngest source always wins.

Stall, combinational from registered state plus issue bypass:
- id_stall = OR over i of (id_rd_en[i] & addr_i!=0 & (busy[addr_i] | (iss_valid & iss_dst==addr_i & !flush))).

Per-register update, first matching rule wins:
1. rst: cnt=0 and unk=0 for every register.
2. flush: cnt=0 and unk=0 for every register. An issue in the same cycle is dropped.
3. iss_valid & iss_dst==r & r!=0:
   - iss_lat>=1: cnt=iss_lat-1 and unk=0.
   - iss_lat==0: cnt=0 and unk=1.
   - Issue overrides a pending entry (WAW: newest wins) and beats a done for the same register.
4. done_valid & done_dst==r: unk=0 and cnt=0.
5. !hold & cnt!=0: cnt decrements by 1.

Resulting behaviour:
- A consumer sitting in ID from the issue cycle stalls for exactly iss_lat cycles when hold stays low. Each hold cycle adds one.
- done_valid for a register that is not busy is ignored.
- stall_cycles increments when id_stall=1 and holds at all-ones once it saturates. rst clears it; flush does not.

## Timing
- Reset values: cnt=0, unk=0 and stall_cycles=0. With idle inputs, id_stall=0 and ex_fwd_sel=0.
- ex_fwd_sel and id_stall have zero latency and form combinational paths from their inputs.
- A scoreboard update is visible on id_stall on the cycle after the edge that records it.
- The issue-cycle stall comes from the combinational bypass, not from stored state.
- Reset or flush asserted mid-countdown clears everything at that edge; id_stall drops the next cycle unless new inputs re-assert it.

## Test plan
- Forward priority: with fwd_wr=2'b11, fwd_dst0=fwd_dst1=5, ex_rd_addr0=5 and ex_rd_en0=1, expect ex_fwd_sel0=1. With fwd_wr=2'b10, expect 2. With addr=0 and both sources writing r0, expect 0.
- Known latency: issue r7 with iss_lat=2 while id_rd_addr0=7 and id_rd_en0=1. Expect id_stall=1 in cycles 0 and 1 and 0 in cycle 2. Repeat with hold=1 in cycle 1 and expect 3 stall cycles.
- Unknown latency: issue r9 with iss_lat=0 and read r9 in ID. Stall persists for 10 cycles. Assert done_valid with done_dst=9 and expect id_stall=0 on the next cycle.
- Simultaneous events: in one cycle, issue r4 with iss_lat=0 and done r4; expect r4 to stay busy. In a later cycle, issue r4 together with flush; expect nothing pending afterwards.
- WAW overwrite: issue r3 with iss_lat=5, then issue r3 with iss_lat=1 on the next cycle. The stall ends after that second cycle.
- Reset and performance counter: accumulate 4 stall cycles and expect stall_cycles=4. Pulse rst while r6 is pending; expect stall_cycles=0, id_stall=0 and r6 no longer busy.
